// File: rtl/alu_sweep_checker.sv
`timescale 1ns / 1ps
// alu_sweep_checker
// On-chip self-test engine for the 4-bit ALU. It sweeps six op codes with A as
// the outer loop and B as the inner loop, each over 0..15. Each ALU response is
// checked against a built-in golden model. The block reports pass/fail, a
// saturating mismatch count and the first failing vector.
module alu_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,   // extra hold cycles per vector before sampling
  parameter int GAP_CYCLES    = 20,  // idle cycles between op groups
  parameter int ERR_W         = 12   // width of the saturating error counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_sel,
  output logic [3:0]       first_a,
  output logic [3:0]       first_b
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_CHECK,
    S_GAP,
    S_DONE
  } state_t;

  localparam int MAX_WAIT = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1) + 1;

  // Terminal counts for the wait states; only meaningful when the state is used.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  // A zero-length wait skips its state entirely.
  localparam state_t VEC_ENTRY = (SETTLE_CYCLES == 0) ? S_CHECK : S_HOLD;
  localparam state_t GAP_ENTRY = (GAP_CYCLES == 0) ? VEC_ENTRY : S_GAP;

  localparam logic [2:0] LAST_OP = 3'd5;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op_idx;
  logic [3:0]       r_sel;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_first_sel;
  logic [3:0]       r_first_a;
  logic [3:0]       r_first_b;

  logic [4:0]       w_expect;
  logic             w_mismatch;
  logic             w_last_vec;
  logic             w_busy;
  logic             w_done;

  // Op code swept in slot idx; the sweep order is fixed.
  function automatic logic [3:0] op_sel(input logic [2:0] idx);
    logic [3:0] sel;
    case (idx)
      3'd0:    sel = 4'b0000;
      3'd1:    sel = 4'b0010;
      3'd2:    sel = 4'b0100;
      3'd3:    sel = 4'b0111;
      3'd4:    sel = 4'b1000;
      default: sel = 4'b1110;
    endcase
    return sel;
  endfunction

  // Golden ALU: {carry, result}. The carry is always bit 4 of A+B, whatever the op.
  function automatic logic [4:0] golden(input logic [3:0] sel,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] sum;
    logic [3:0] res;
    sum = {1'b0, a} + {1'b0, b};
    case (sel)
      4'b0000: res = sum[3:0];
      4'b0010: res = a * b;
      4'b0100: res = {a[2:0], 1'b0};
      4'b0111: res = {a[0], a[3:1]};
      4'b1000: res = a & b;
      4'b1110: res = {3'b000, (a > b)};
      default: res = 4'b0000;
    endcase
    return {sum[4], res};
  endfunction

  assign w_expect   = golden(r_sel, r_a, r_b);
  assign w_mismatch = (alu_out != w_expect[3:0]) || (alu_carry != w_expect[4]);
  assign w_last_vec = (r_a == 4'hF) && (r_b == 4'hF);

  // Next-state decode and status flags derived from the current state.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = VEC_ENTRY;
      end
      S_HOLD: begin
        w_busy = 1'b1;
        if (r_cnt == SETTLE_LAST) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_busy = 1'b1;
        if (!w_last_vec)              w_state_nxt = VEC_ENTRY;
        else if (r_op_idx == LAST_OP) w_state_nxt = S_DONE;
        else                          w_state_nxt = GAP_ENTRY;
      end
      S_GAP: begin
        w_busy = 1'b1;
        if (r_cnt == GAP_LAST) w_state_nxt = VEC_ENTRY;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (start) w_state_nxt = VEC_ENTRY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Wait counter: restarts on every state change, runs inside HOLD and GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != w_state_nxt) begin
      r_cnt <= '0;
    end else if ((r_state == S_HOLD) || (r_state == S_GAP)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Vector generator: launches the sweep and advances B, then A, then the op after each check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_idx <= 3'd0;
      r_sel    <= 4'b0000;
      r_a      <= 4'h0;
      r_b      <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op_idx <= 3'd0;
            r_sel    <= op_sel(3'd0);
            r_a      <= 4'h0;
            r_b      <= 4'h0;
          end
        end
        S_CHECK: begin
          if (r_b != 4'hF) begin
            r_b <= r_b + 4'h1;
          end else if (r_a != 4'hF) begin
            r_b <= 4'h0;
            r_a <= r_a + 4'h1;
          end else if (r_op_idx != LAST_OP) begin
            r_a      <= 4'h0;
            r_b      <= 4'h0;
            r_op_idx <= r_op_idx + 3'd1;
            r_sel    <= op_sel(r_op_idx + 3'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result tracking: clears at launch, counts mismatches and latches the first failing vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= '0;
      r_first_sel <= 4'h0;
      r_first_a   <= 4'h0;
      r_first_b   <= 4'h0;
    end else if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) begin
      r_err       <= '0;
      r_first_sel <= 4'h0;
      r_first_a   <= 4'h0;
      r_first_b   <= 4'h0;
    end else if ((r_state == S_CHECK) && w_mismatch) begin
      if (r_err != '1) r_err <= r_err + ERR_W'(1);
      if (r_err == '0) begin
        r_first_sel <= r_sel;
        r_first_a   <= r_a;
        r_first_b   <= r_b;
      end
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign busy      = w_busy;
  assign done      = w_done;
  assign pass      = w_done && (r_err == '0);
  assign err_count = r_err;
  assign first_sel = r_first_sel;
  assign first_a   = r_first_a;
  assign first_b   = r_first_b;

endmodule

// File: tb/tb_alu_sweep_checker.sv
`timescale 1ns / 1ps
// Bench for alu_sweep_checker. Three instances share clock and reset. The main
// one (SETTLE=1, GAP=20) sits beside an ALU model with selectable faults. A
// second one (SETTLE=0) has its drive sequence traced cycle by cycle. A third
// one (ERR_W=4) has its carry tied low so its error counter saturates.
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main instance ----------------
  logic        m_start;
  logic [3:0]  m_a, m_b, m_sel, m_out, m_fsel, m_fa, m_fb;
  logic        m_carry, m_busy, m_done, m_pass;
  logic [11:0] m_err;
  logic [4:0]  m_ref;
  int          fault;

  // ---------------- SETTLE=0 instance ----------------
  logic        z_start;
  logic [3:0]  z_a, z_b, z_sel, z_out, z_fsel, z_fa, z_fb;
  logic        z_carry, z_busy, z_done, z_pass;
  logic [11:0] z_err;
  logic [4:0]  z_ref;

  // ---------------- ERR_W=4 instance ----------------
  logic        s_start;
  logic [3:0]  s_a, s_b, s_sel, s_out, s_fsel, s_fa, s_fb;
  logic        s_carry, s_busy, s_done, s_pass;
  logic [3:0]  s_err;
  logic [4:0]  s_ref;

  // Reference ALU built from integer arithmetic: {carry, result}.
  function automatic logic [4:0] ref_alu(input logic [3:0] sel, input logic [3:0] a,
                                         input logic [3:0] b);
    int unsigned ia, ib;
    logic [31:0] r;
    ia = a;
    ib = b;
    case (sel)
      4'b0000: r = ia + ib;
      4'b0010: r = ia * ib;
      4'b0100: r = ia * 2;
      4'b0111: r = (ia >> 1) | ((ia & 1) << 3);
      4'b1000: r = ia & ib;
      4'b1110: r = (ia > ib) ? 1 : 0;
      default: r = 0;
    endcase
    return {((ia + ib) >= 16) ? 1'b1 : 1'b0, r[3:0]};
  endfunction

  // Main ALU with fault modes: 1 carry tied 0, 2 bit0 flipped on 1110, 3 one bad AND result.
  always_comb begin
    m_ref   = ref_alu(m_sel, m_a, m_b);
    m_out   = m_ref[3:0];
    m_carry = m_ref[4];
    if (fault == 1) m_carry = 1'b0;
    if (fault == 2 && m_sel == 4'b1110) m_out[0] = ~m_out[0];
    if (fault == 3 && m_sel == 4'b1000 && m_a == 4'd5 && m_b == 4'd3) m_out = 4'h0;
  end

  // Golden ALU for the SETTLE=0 instance.
  always_comb begin
    z_ref   = ref_alu(z_sel, z_a, z_b);
    z_out   = z_ref[3:0];
    z_carry = z_ref[4];
  end

  // Carry-stuck ALU for the saturation instance.
  always_comb begin
    s_ref   = ref_alu(s_sel, s_a, s_b);
    s_out   = s_ref[3:0];
    s_carry = 1'b0;
  end

  alu_sweep_checker #(.SETTLE_CYCLES(1), .GAP_CYCLES(20), .ERR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(m_start),
    .alu_a(m_a), .alu_b(m_b), .alu_sel(m_sel), .alu_out(m_out), .alu_carry(m_carry),
    .busy(m_busy), .done(m_done), .pass(m_pass), .err_count(m_err),
    .first_sel(m_fsel), .first_a(m_fa), .first_b(m_fb)
  );

  alu_sweep_checker #(.SETTLE_CYCLES(0), .GAP_CYCLES(20), .ERR_W(12)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(z_start),
    .alu_a(z_a), .alu_b(z_b), .alu_sel(z_sel), .alu_out(z_out), .alu_carry(z_carry),
    .busy(z_busy), .done(z_done), .pass(z_pass), .err_count(z_err),
    .first_sel(z_fsel), .first_a(z_fa), .first_b(z_fb)
  );

  alu_sweep_checker #(.SETTLE_CYCLES(1), .GAP_CYCLES(20), .ERR_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .alu_a(s_a), .alu_b(s_b), .alu_sel(s_sel), .alu_out(s_out), .alu_carry(s_carry),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .first_sel(s_fsel), .first_a(s_fa), .first_b(s_fb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Launches a sweep on the main instance and waits for done.
  // Optionally re-pulses start 100 cycles in, while busy.
  task automatic run_main(input string tag, input bit poke_busy);
    int n;
    @(negedge clk) m_start = 1'b1;
    @(negedge clk) m_start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(m_busy), 32'd1);
    check({tag, "_cleared_after_start"}, {m_done, m_err, m_fsel, m_fa, m_fb}, 32'd0);
    n = 0;
    while (!m_done && n < 5000) begin
      @(negedge clk);
      n++;
      if (poke_busy && n == 100) begin
        m_start = 1'b1;
        @(negedge clk) m_start = 1'b0;
        n++;
      end
    end
    check({tag, "_cycles"}, 32'(n), 32'd3172);
    check({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
  endtask

  // Drive trace of the SETTLE=0 instance.
  int zbad;
  int zidx;
  int zfirst;

  task automatic expect_drive(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    if ({z_sel, z_a, z_b} !== {s, a, b}) begin
      if (zfirst < 0) zfirst = zidx;
      zbad++;
    end
    zidx++;
    @(negedge clk);
  endtask

  typedef struct {
    string      name;
    int         fault;
    bit         poke;
    int         err;
    logic       pass;
    logic [3:0] fsel;
    logic [3:0] fa;
    logic [3:0] fb;
  } vec_t;

  vec_t tbl[5];
  logic [3:0] sels[6];

  initial begin
    int n;
    tbl[0] = '{"golden",     0, 1'b0, 0,   1'b1, 4'b0000, 4'd0, 4'd0};
    tbl[1] = '{"carry0",     1, 1'b0, 720, 1'b0, 4'b0000, 4'd1, 4'd15};
    tbl[2] = '{"inv1110",    2, 1'b0, 256, 1'b0, 4'b1110, 4'd0, 4'd0};
    tbl[3] = '{"and_5_3",    3, 1'b0, 1,   1'b0, 4'b1000, 4'd5, 4'd3};
    tbl[4] = '{"rerun_poke", 0, 1'b1, 0,   1'b1, 4'b0000, 4'd0, 4'd0};
    sels[0] = 4'b0000; sels[1] = 4'b0010; sels[2] = 4'b0100;
    sels[3] = 4'b0111; sels[4] = 4'b1000; sels[5] = 4'b1110;

    rst_n   = 1'b0;
    m_start = 1'b0;
    z_start = 1'b0;
    s_start = 1'b0;
    fault   = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {m_a, m_b, m_sel, m_busy, m_done, m_pass, m_fsel, m_fa, m_fb}, 32'd0);
    check("reset_err", 32'(m_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven sweeps; every row after the first launches from DONE.
    foreach (tbl[i]) begin
      fault = tbl[i].fault;
      run_main(tbl[i].name, tbl[i].poke);
      check({tbl[i].name, "_done"}, 32'(m_done), 32'd1);
      check({tbl[i].name, "_pass"}, 32'(m_pass), 32'(tbl[i].pass));
      check({tbl[i].name, "_err"}, 32'(m_err), 32'(tbl[i].err));
      check({tbl[i].name, "_first"}, {m_fsel, m_fa, m_fb},
            {tbl[i].fsel, tbl[i].fa, tbl[i].fb});
      repeat (3) @(negedge clk);
    end

    // Asynchronous reset mid-sweep, with errors already accumulated.
    fault = 1;
    @(negedge clk) m_start = 1'b1;
    @(negedge clk) m_start = 1'b0;
    n = 0;
    while (!(m_sel == 4'b0100 && m_a == 4'd7) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_op0100_a7", 32'(m_sel == 4'b0100 && m_a == 4'd7), 32'd1);
    check("errs_before_reset", 32'(m_err != 12'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {m_a, m_b, m_sel, m_busy, m_done, m_pass, m_fsel, m_fa, m_fb}, 32'd0);
    check("async_reset_err", 32'(m_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    fault = 0;
    @(negedge clk);
    run_main("after_reset", 1'b0);
    check("after_reset_pass", {m_done, m_pass, m_err}, {1'b1, 1'b1, 12'd0});

    // Exact drive sequence at SETTLE=0, including the held outputs through each gap.
    zbad   = 0;
    zidx   = 0;
    zfirst = -1;
    @(negedge clk) z_start = 1'b1;
    @(negedge clk) z_start = 1'b0;
    for (int op = 0; op < 6; op++) begin
      if (op > 0) repeat (20) expect_drive(sels[op], 4'd0, 4'd0);
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          expect_drive(sels[op], 4'(a), 4'(b));
    end
    if (zbad != 0) $display("first drive deviation at cycle %0d", zfirst);
    check("z_drive_seq_bad", 32'(zbad), 32'd0);
    check("z_done_on_time", {z_done, z_busy}, {1'b1, 1'b0});
    check("z_pass", {z_pass, z_err}, {1'b1, 12'd0});

    // Saturating 4-bit error count under a stuck carry.
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    n = 0;
    while (!s_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("s_cycles", 32'(n), 32'd3172);
    check("s_err_saturated", 32'(s_err), 32'd15);
    check("s_pass", 32'(s_pass), 32'd0);
    check("s_first", {s_fsel, s_fa, s_fb}, {4'b0000, 4'd1, 4'd15});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Runaway guard.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
